// File: rtl/logilib_chk_pkg.sv
// Shared types and constants for the gate sweep checker.
//   chk_state_e : sweep FSM state encoding
//   TT_*        : 2-input truth tables, bit i = output for input vector i
package logilib_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_e;

    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus-and-check stage for one N_IN-input combinational gate.
// Drives every input vector in ascending order, holds each for SETTLE cycles,
// samples the gate output and compares it against the EXPECT truth table.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : single-cycle sweep request (honoured in IDLE/DONE)
//   dut_in            : vector driven to the gate, bit 0 = first gate input
//   dut_out           : gate output under test
//   busy / done       : sweep in progress / sweep finished
//   pass              : done with zero mismatches
//   fail_cnt          : number of mismatching vectors
//   first_fail_vec    : first mismatching vector, valid when first_fail_valid
module gate_sweep_checker
    import logilib_chk_pkg::*;
#(
    parameter int unsigned                N_IN   = 2,
    parameter logic [(1 << N_IN) - 1 : 0] EXPECT = 4'b1110,
    parameter int unsigned                SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     fail_cnt,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int unsigned FC_W  = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_VEC   = '1;

    chk_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;
    logic [FC_W-1:0]   fail_cnt_d;
    logic [N_IN-1:0]   first_fail_vec_d;
    logic              first_fail_valid_d;
    logic              mismatch_c;

    // Case-inequality so an X/Z gate output counts as a mismatch in simulation.
    assign mismatch_c = (dut_out !== EXPECT[dut_in]);

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dut_in           <= dut_in_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            fail_cnt         <= fail_cnt_d;
            first_fail_vec   <= first_fail_vec_d;
            first_fail_valid <= first_fail_valid_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        dut_in_d           = dut_in;
        busy_d             = busy;
        done_d             = done;
        pass_d             = pass;
        fail_cnt_d         = fail_cnt;
        first_fail_vec_d   = first_fail_vec;
        first_fail_valid_d = first_fail_valid;

        case (state_q)
            // A restart from DONE behaves exactly like a start from IDLE.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d            = ST_SETTLE;
                    dut_in_d           = '0;
                    cnt_d              = CNT_RELOAD;
                    busy_d             = 1'b1;
                    done_d             = 1'b0;
                    pass_d             = 1'b0;
                    fail_cnt_d         = '0;
                    first_fail_vec_d   = '0;
                    first_fail_valid_d = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (mismatch_c) begin
                    fail_cnt_d = fail_cnt + FC_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec_d   = dut_in;
                        first_fail_valid_d = 1'b1;
                    end
                end
                // Sweep ends after the all-ones vector; dut_in never wraps.
                if (dut_in == LAST_VEC) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_cnt_d == '0);
                end else begin
                    state_d  = ST_SETTLE;
                    dut_in_d = dut_in + N_IN'(1);
                    cnt_d    = CNT_RELOAD;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: three instances (2-input OR
// expectation, 2-input AND expectation, 3-input XOR with SETTLE=1) driven by
// behavioural gates whose truth tables the bench chooses, checked against a
// plain truth-table comparison model.
module tb_gate_sweep_checker;
    import logilib_chk_pkg::*;

    localparam logic [7:0] EXP2 = 8'h96;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] tt0, tt1;
    logic [7:0] tt2;

    logic [1:0] d_in0, d_in1, ffv0, ffv1;
    logic [2:0] d_in2, ffv2, fc0, fc1;
    logic [3:0] fc2;
    logic       out0, out1, out2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic       pass0, pass1, pass2, ffok0, ffok1, ffok2;

    // Behavioural gates under test.
    assign out0 = tt0[d_in0];
    assign out1 = tt1[d_in1];
    assign out2 = tt2[d_in2];

    gate_sweep_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(d_in0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0),
        .first_fail_vec(ffv0), .first_fail_valid(ffok0)
    );

    gate_sweep_checker #(.EXPECT(TT_AND)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(d_in1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    gate_sweep_checker #(.N_IN(3), .EXPECT(EXP2), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(d_in2), .dut_out(out2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fc2),
        .first_fail_vec(ffv2), .first_fail_valid(ffok2)
    );

    // Reference: count vectors where gate and expectation disagree.
    function automatic void model(input int nvec, input logic [7:0] gate_tt,
                                  input logic [7:0] exp_tt, output int fc,
                                  output int ffv, output bit ffok);
        fc = 0; ffv = 0; ffok = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            if (gate_tt[v] != exp_tt[v]) begin
                fc++;
                if (!ffok) begin
                    ffv  = v;
                    ffok = 1'b1;
                end
            end
        end
    endfunction

    // Vector expected on dut_in j cycles after the start edge.
    function automatic int exp_vec(input int j, input int per, input int nvec);
        return (j < per * nvec) ? j / per : nvec - 1;
    endfunction

    // Start edge E0 is the second posedge; returns at E0 + 1ns.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Full sweep on all instances; start re-pulsed after cycles ign_a/ign_b.
    task automatic run_sweep(input int ign_a, input int ign_b);
        int e_fc0, e_fc1, e_fc2, e_v0, e_v1, e_v2;
        bit e_ok0, e_ok1, e_ok2;
        model(4, {4'b0, tt0}, {4'b0, TT_OR},  e_fc0, e_v0, e_ok0);
        model(4, {4'b0, tt1}, {4'b0, TT_AND}, e_fc1, e_v1, e_ok1);
        model(8, tt2, EXP2, e_fc2, e_v2, e_ok2);
        pulse_start();
        for (int j = 0; j <= 16; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            checks++;
            if ({busy0, done0, d_in0} !== {(j < 12), (j >= 12), 2'(exp_vec(j, 3, 4))}) begin
                errors++;
                $display("FAIL seq0 j=%0d: busy/done/dut_in got %b expected %b", j,
                         {busy0, done0, d_in0}, {(j < 12), (j >= 12), 2'(exp_vec(j, 3, 4))});
            end
            checks++;
            if ({busy1, done1, d_in1} !== {(j < 12), (j >= 12), 2'(exp_vec(j, 3, 4))}) begin
                errors++;
                $display("FAIL seq1 j=%0d: busy/done/dut_in got %b expected %b", j,
                         {busy1, done1, d_in1}, {(j < 12), (j >= 12), 2'(exp_vec(j, 3, 4))});
            end
            checks++;
            if ({busy2, done2, d_in2} !== {(j < 16), (j >= 16), 3'(exp_vec(j, 2, 8))}) begin
                errors++;
                $display("FAIL seq2 j=%0d: busy/done/dut_in got %b expected %b", j,
                         {busy2, done2, d_in2}, {(j < 16), (j >= 16), 3'(exp_vec(j, 2, 8))});
            end
            if (j == 0) begin
                checks++;
                if ({fc0, ffok0, pass0, fc1, ffok1, pass1, fc2, ffok2, pass2} !== '0) begin
                    errors++;
                    $display("FAIL clear_on_start: results got %h expected 0",
                             {fc0, ffok0, pass0, fc1, ffok1, pass1, fc2, ffok2, pass2});
                end
            end
            if (j == 12) begin
                checks++;
                if ({pass0, pass1} !== {(e_fc0 == 0), (e_fc1 == 0)}) begin
                    errors++;
                    $display("FAIL pass_with_done: pass0/pass1 got %b expected %b",
                             {pass0, pass1}, {(e_fc0 == 0), (e_fc1 == 0)});
                end
            end
            if (ign_a == j || ign_b == j) start = 1'b1;
        end
        checks++;
        if ({fc0, ffv0, ffok0, pass0} !== {3'(e_fc0), 2'(e_v0), e_ok0, (e_fc0 == 0)}) begin
            errors++;
            $display("FAIL result0 tt=%b: fc/vec/valid/pass got %b expected %b", tt0,
                     {fc0, ffv0, ffok0, pass0}, {3'(e_fc0), 2'(e_v0), e_ok0, (e_fc0 == 0)});
        end
        checks++;
        if ({fc1, ffv1, ffok1, pass1} !== {3'(e_fc1), 2'(e_v1), e_ok1, (e_fc1 == 0)}) begin
            errors++;
            $display("FAIL result1 tt=%b: fc/vec/valid/pass got %b expected %b", tt1,
                     {fc1, ffv1, ffok1, pass1}, {3'(e_fc1), 2'(e_v1), e_ok1, (e_fc1 == 0)});
        end
        checks++;
        if ({fc2, ffv2, ffok2, pass2} !== {4'(e_fc2), 3'(e_v2), e_ok2, (e_fc2 == 0)}) begin
            errors++;
            $display("FAIL result2 tt=%b: fc/vec/valid/pass got %b expected %b", tt2,
                     {fc2, ffv2, ffok2, pass2}, {4'(e_fc2), 3'(e_v2), e_ok2, (e_fc2 == 0)});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tt0 = TT_OR; tt1 = TT_AND; tt2 = EXP2;
        #12;
        checks++;
        if ({d_in0, busy0, done0, pass0, fc0, ffv0, ffok0,
             d_in1, busy1, done1, pass1, fc1, ffv1, ffok1,
             d_in2, busy2, done2, pass2, fc2, ffv2, ffok2} !== '0) begin
            errors++;
            $display("FAIL reset_values: outputs not all zero during reset");
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_gate_or();
        tt0 = TT_OR; tt1 = TT_OR; tt2 = EXP2;
        run_sweep(-1, -1);
    endtask

    task automatic test_stuck_zero();
        tt0 = 4'b0; tt1 = 4'b0; tt2 = 8'b0;
        run_sweep(-1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            tt0 = 4'($urandom());
            tt1 = 4'($urandom());
            tt2 = 8'($urandom());
            run_sweep(-1, -1);
        end
    endtask

    task automatic test_start_while_busy();
        tt0 = TT_NAND; tt1 = TT_AND; tt2 = 8'($urandom());
        run_sweep(2, 7);
    endtask

    task automatic test_back_to_back();
        tt0 = TT_XOR; tt1 = TT_NOR; tt2 = 8'($urandom());
        run_sweep(-1, -1);
        run_sweep(-1, -1);
    endtask

    task automatic test_reset_mid();
        tt0 = 4'b0; tt1 = 4'b0; tt2 = 8'b0;
        pulse_start();
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({d_in0, busy0, done0, pass0, fc0, ffv0, ffok0,
             d_in1, busy1, done1, pass1, fc1, ffv1, ffok1,
             d_in2, busy2, done2, pass2, fc2, ffv2, ffok2} !== '0) begin
            errors++;
            $display("FAIL async_reset_mid: outputs not cleared before next edge");
        end
        @(posedge clk); #1;
        checks++;
        if ({busy0, busy1, busy2, fc0, fc1, fc2} !== '0) begin
            errors++;
            $display("FAIL reset_hold: busy/fail_cnt got %h expected 0",
                     {busy0, busy1, busy2, fc0, fc1, fc2});
        end
        rst_n = 1'b1;
        tt0 = TT_OR; tt1 = TT_AND; tt2 = EXP2;
        run_sweep(-1, -1);
        checks++;
        if ({pass0, pass1, pass2} !== 3'b111) begin
            errors++;
            $display("FAIL clean_after_reset: pass got %b expected 111", {pass0, pass1, pass2});
        end
    endtask

    initial begin
        test_reset();
        test_gate_or();
        test_stuck_zero();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
